// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and EX-stage forwarding selects.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    // MEM result wins over WB result; register 0 is never forwarded.
    function automatic fwd_e fwd_select(
        input logic       mem_regwrite,
        input logic [4:0] mem_wn,
        input logic       wb_regwrite,
        input logic [4:0] wb_wn,
        input logic [4:0] src
    );
        if (mem_regwrite && (mem_wn != 5'd0) && (mem_wn == src)) begin
            return FWD_MEM;
        end else if (wb_regwrite && (wb_wn != 5'd0) && (wb_wn == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and register-control outputs.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_memread;
    logic [4:0]       ex_wn;
    logic             ex_jump;
    logic             mem_regwrite;
    logic [4:0]       mem_wn;
    logic             wb_regwrite;
    logic [4:0]       wb_wn;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             memwb_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_wn, ex_jump,
               mem_regwrite, mem_wn, wb_regwrite, wb_wn, mem_req, mem_ready,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               fwd_a, fwd_b, mem_timeout, state, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_wn, ex_jump,
               mem_regwrite, mem_wn, wb_regwrite, wb_wn, mem_req, mem_ready,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               fwd_a, fwd_b, mem_timeout, state, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: stalls, flushes, memory-wait freeze with timeout,
// EX forwarding selects and saturating stall/flush counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic frozen;
    logic load_use;
    logic jump_applied;
    logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        frozen   = (state_q == TIMEOUT) || (hz.mem_req && !hz.mem_ready);
        load_use = hz.ex_memread && (hz.ex_wn != 5'd0) &&
                   ((hz.ex_wn == hz.id_rs) || (hz.id_uses_rt && (hz.ex_wn == hz.id_rt)));

        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        memwb_we     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        jump_applied = 1'b0;

        // Freeze outranks jump: EX/MEM is held so the jump re-presents on release.
        if (rst) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_we    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (frozen) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
        end else if (hz.ex_jump) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            jump_applied = 1'b1;
        end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end

        if (rst) begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end else begin
            fwd_a = fwd_select(hz.mem_regwrite, hz.mem_wn, hz.wb_regwrite, hz.wb_wn, hz.ex_rs);
            fwd_b = fwd_select(hz.mem_regwrite, hz.mem_wn, hz.wb_regwrite, hz.wb_wn, hz.ex_rt);
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                    state_d       = TIMEOUT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (!rst && !pc_we),
        .count (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (jump_applied),
        .count (hz.flush_events)
    );

    assign hz.pc_we       = pc_we;
    assign hz.ifid_we     = ifid_we;
    assign hz.idex_we     = idex_we;
    assign hz.exmem_we    = exmem_we;
    assign hz.memwb_we    = memwb_we;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_flush = memwb_flush;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=4, CNT_W=3).
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    // {pc, ifid, idex, exmem, memwb}_we, {ifid, idex, exmem, memwb}_flush
    localparam logic [8:0] C_RESET  = 9'b00000_1111;
    localparam logic [8:0] C_NORMAL = 9'b11111_0000;
    localparam logic [8:0] C_LDUSE  = 9'b00111_0100;
    localparam logic [8:0] C_JUMP   = 9'b11111_1100;
    localparam logic [8:0] C_FREEZE = 9'b00001_0001;

    pipeline_hazard_ctrl_if #(.CNT_W(3)) bus ();

    pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [8:0] exp);
        chk(tag, {23'd0, bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush}, {23'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
        bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_memread = 1'b0; bus.ex_wn = '0; bus.ex_jump = 1'b0;
        bus.mem_regwrite = 1'b0; bus.mem_wn = '0; bus.wb_regwrite = 1'b0; bus.wb_wn = '0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    initial begin
        idle();
        bus.mem_regwrite = 1'b1; bus.mem_wn = 5'd3; bus.ex_rs = 5'd3;
        #1;
        chk_ctrl("rst_ctrl", C_RESET);
        chk("rst_fwd_a", {30'd0, bus.fwd_a}, 32'd0);
        tick(); tick();
        chk("rst_state", {30'd0, bus.state}, 32'd0);
        chk("rst_stall", {29'd0, bus.stall_cycles}, 32'd0);
        chk("rst_flush", {29'd0, bus.flush_events}, 32'd0);
        chk("rst_timeout", {31'd0, bus.mem_timeout}, 32'd0);
        rst = 1'b0;
        idle();
        #1;
        chk_ctrl("normal_ctrl", C_NORMAL);

        // Load-use on rs, then ex_wn = 0 never stalls, then rt gated by id_uses_rt.
        bus.ex_memread = 1'b1; bus.ex_wn = 5'd5; bus.id_rs = 5'd5;
        #1 chk_ctrl("lduse_rs", C_LDUSE);
        tick();
        bus.ex_wn = 5'd0; bus.id_rs = 5'd0;
        #1 chk_ctrl("lduse_r0", C_NORMAL);
        chk("lduse_stall1", {29'd0, bus.stall_cycles}, 32'd1);
        bus.ex_wn = 5'd6; bus.id_rs = 5'd1; bus.id_rt = 5'd6; bus.id_uses_rt = 1'b0;
        #1 chk_ctrl("lduse_rt_unused", C_NORMAL);
        bus.id_uses_rt = 1'b1;
        #1 chk_ctrl("lduse_rt", C_LDUSE);
        tick();
        chk("lduse_stall2", {29'd0, bus.stall_cycles}, 32'd2);

        // Jump alone, then jump together with load-use.
        idle();
        bus.ex_jump = 1'b1;
        #1 chk_ctrl("jump_ctrl", C_JUMP);
        tick();
        chk("jump_flush1", {29'd0, bus.flush_events}, 32'd1);
        bus.ex_memread = 1'b1; bus.ex_wn = 5'd5; bus.id_rs = 5'd5;
        #1 chk_ctrl("jump_lduse", C_JUMP);
        tick();
        chk("jump_flush2", {29'd0, bus.flush_events}, 32'd2);
        chk("jump_lduse_stall", {29'd0, bus.stall_cycles}, 32'd2);

        // Memory wait: 3 frozen cycles with a jump held, released by mem_ready.
        idle();
        bus.mem_req = 1'b1; bus.ex_jump = 1'b1;
        #1 chk_ctrl("mw_freeze0", C_FREEZE);
        chk("mw_state0", {30'd0, bus.state}, 32'd0);
        tick();
        chk("mw_state1", {30'd0, bus.state}, 32'd1);
        chk_ctrl("mw_freeze1", C_FREEZE);
        tick();
        chk_ctrl("mw_freeze2", C_FREEZE);
        tick();
        bus.mem_ready = 1'b1;
        #1 chk("mw_state3", {30'd0, bus.state}, 32'd1);
        chk_ctrl("mw_release_jump", C_JUMP);
        chk("mw_stall", {29'd0, bus.stall_cycles}, 32'd5);
        chk("mw_flush_pre", {29'd0, bus.flush_events}, 32'd2);
        tick();
        chk("mw_state_run", {30'd0, bus.state}, 32'd0);
        chk("mw_flush_post", {29'd0, bus.flush_events}, 32'd3);

        // Timeout: one RUN cycle plus four MEM_WAIT cycles without ready.
        idle();
        bus.mem_req = 1'b1;
        tick(); tick(); tick(); tick();
        chk("to_state_wait", {30'd0, bus.state}, 32'd1);
        chk("to_flag_pre", {31'd0, bus.mem_timeout}, 32'd0);
        tick();
        chk("to_state", {30'd0, bus.state}, 32'd2);
        chk("to_flag", {31'd0, bus.mem_timeout}, 32'd1);
        chk("to_stall_sat", {29'd0, bus.stall_cycles}, 32'd7);
        bus.mem_req = 1'b0; bus.mem_ready = 1'b1; bus.ex_jump = 1'b1;
        #1 chk_ctrl("to_freeze_ready", C_FREEZE);
        tick();
        chk("to_state_sticky", {30'd0, bus.state}, 32'd2);
        chk("to_flag_sticky", {31'd0, bus.mem_timeout}, 32'd1);
        chk("to_flush_held", {29'd0, bus.flush_events}, 32'd3);
        rst = 1'b1;
        #1 chk_ctrl("to_rst_ctrl", C_RESET);
        tick();
        rst = 1'b0;
        idle();
        #1 chk("rec_state", {30'd0, bus.state}, 32'd0);
        chk("rec_flag", {31'd0, bus.mem_timeout}, 32'd0);
        chk("rec_stall", {29'd0, bus.stall_cycles}, 32'd0);
        chk("rec_flush", {29'd0, bus.flush_events}, 32'd0);
        chk_ctrl("rec_ctrl", C_NORMAL);

        // Forwarding priority and register 0.
        bus.mem_regwrite = 1'b1; bus.mem_wn = 5'd7; bus.wb_regwrite = 1'b1; bus.wb_wn = 5'd7;
        bus.ex_rs = 5'd7; bus.ex_rt = 5'd7;
        #1 chk("fwd_a_mem", {30'd0, bus.fwd_a}, 32'd2);
        chk("fwd_b_mem", {30'd0, bus.fwd_b}, 32'd2);
        bus.mem_regwrite = 1'b0;
        #1 chk("fwd_a_wb", {30'd0, bus.fwd_a}, 32'd1);
        bus.mem_regwrite = 1'b1; bus.ex_rt = 5'd3; bus.wb_wn = 5'd3;
        #1 chk("fwd_a_mix", {30'd0, bus.fwd_a}, 32'd2);
        chk("fwd_b_mix", {30'd0, bus.fwd_b}, 32'd1);
        bus.mem_wn = 5'd0; bus.wb_wn = 5'd0; bus.ex_rs = 5'd0; bus.ex_rt = 5'd0;
        #1 chk("fwd_a_r0", {30'd0, bus.fwd_a}, 32'd0);
        chk("fwd_b_r0", {30'd0, bus.fwd_b}, 32'd0);

        // Saturation of both counters.
        idle();
        bus.ex_memread = 1'b1; bus.ex_wn = 5'd5; bus.id_rs = 5'd5;
        for (int i = 0; i < 6; i++) tick();
        chk("sat_stall6", {29'd0, bus.stall_cycles}, 32'd6);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_stall9", {29'd0, bus.stall_cycles}, 32'd7);
        idle();
        bus.ex_jump = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("sat_flush8", {29'd0, bus.flush_events}, 32'd7);
        chk("sat_stall_hold", {29'd0, bus.stall_cycles}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-register write-enable and flush (bubble) controls, plus EX-stage forwarding selects.
- Handles load-use stalls, jump/jal flushes, and multi-cycle data-memory waits with a timeout.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
- MAX_WAIT, 16: memory-wait cycles allowed before timeout (≥1).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- id_rs  in  5  ID-stage source register A
- id_rt  in  5  ID-stage source register B
- id_uses_rt  in  1  ID instruction reads rt
- ex_rs  in  5  EX-stage source A
- ex_rt  in  5  EX-stage source B
- ex_memread  in  1  EX instruction is a load
- ex_wn  in  5  EX destination register
- ex_jump  in  1  jump/jal resolved in EX
- mem_regwrite  in  1  MEM-stage writes register file
- mem_wn  in  5  MEM destination
- wb_regwrite  in  1  WB-stage writes register file
- wb_wn  in  5  WB destination
- mem_req  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes this cycle
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (all-zero controls)
- fwd_a, fwd_b  out  2  00 = regfile, 10 = MEM result, 01 = WB result
- mem_timeout  out  1  sticky error flag
- state  out  2  FSM state
- stall_cycles  out  CNT_W  saturating count
- flush_events  out  CNT_W  saturating count

Behaviour:
- Reset is rst, synchronous, active-high; clock clk. On reset: state = RUN, wait_cnt = 0, mem_timeout = 0, both counters = 0.
- While rst is high (combinational outputs): all *_we = 0, all *_flush = 1, fwd = 00.
- FSM states: RUN = 0, MEM_WAIT = 1, TIMEOUT = 2.
  - RUN → MEM_WAIT when mem_req && !mem_ready.
  - MEM_WAIT → RUN when mem_ready; wait_cnt cleared.
  - MEM_WAIT → TIMEOUT when wait_cnt == MAX_WAIT-1 && !mem_ready.
  - TIMEOUT is terminal until rst.
- Memory freeze applies whenever mem_req && !mem_ready, in RUN or MEM_WAIT, in the same cycle (combinational):
  - pc/ifid/idex/exmem_we = 0.
  - memwb_we = 1, memwb_flush = 1 (bubble to WB).
  - Other flushes = 0.
- TIMEOUT: same freeze regardless of mem_ready; mem_timeout = 1.
- wait_cnt increments each MEM_WAIT cycle without mem_ready. It is only consulted in MEM_WAIT.
- Priority when not frozen: jump > load-use > normal.
  - Jump (ex_jump): all we = 1; ifid_flush = 1, idex_flush = 1; no stall. flush_events++.
  - Load-use: ex_memread && ex_wn != 0 && (ex_wn == id_rs || (id_uses_rt && ex_wn == id_rt)) gives pc_we = 0, ifid_we = 0, idex_flush = 1. The remaining enables = 1. One bubble per hazard; the condition clears naturally the next cycle.
  - Normal: all we = 1, all flush = 0.
- Freeze + ex_jump in the same cycle: freeze wins. EX/MEM is held, so ex_jump re-presents and is applied on the release cycle. flush_events counts once, on the applied cycle.
- Forwarding (combinational, independent of state):
  - fwd_a = 10 if mem_regwrite && mem_wn != 0 && mem_wn == ex_rs.
  - Else 01 if wb_regwrite && wb_wn != 0 && wb_wn == ex_rs.
  - Else 00.
  - fwd_b is identical using ex_rt. The MEM match has priority.
- stall_cycles increments every non-reset cycle with pc_we = 0 (freeze, load-use, TIMEOUT). It saturates at all-ones.
- flush_events saturates at all-ones.
- Reset mid-wait returns to RUN next edge; counters are cleared.

Decomposition:
- Shared package holds the state encodings (RUN/MEM_WAIT/TIMEOUT) and the forwarding encodings (FWD_RF/FWD_MEM/FWD_WB).
- One natural sub-module: sat_counter (parameterized width, synchronous clear, increment enable), instantiated twice.

Test Plan:
1. Load-use: ex_memread = 1, ex_wn = 5, id_rs = 5 for one cycle → pc_we = 0, ifid_we = 0, idex_flush = 1 that cycle; stall_cycles = 1. Same with ex_wn = 0 → no stall.
2. Jump: ex_jump = 1 → ifid_flush = idex_flush = 1, pc_we = 1, flush_events = 1. Jump + load-use together → no stall, flush only.
3. Memory wait: mem_req = 1, mem_ready low 3 cycles then high → 3 frozen cycles with memwb_flush = 1, state = MEM_WAIT, then RUN; stall_cycles = 3. Jump held during the freeze is applied on the release cycle.
4. Timeout: MAX_WAIT = 4, mem_ready never → TIMEOUT after 4 wait cycles, mem_timeout = 1 sticky. Later mem_ready = 1 has no effect; rst recovers to RUN with counters = 0.
5. Forwarding: mem_wn = wb_wn = 7, both regwrite, ex_rs = 7 → fwd_a = 10. Drop mem_regwrite → 01. Register 0 → 00.
6. Saturation: CNT_W = 3, 9 stall cycles → stall_cycles = 7.
